// File: rtl/asic_eval_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// asic_eval_sequencer
//
// Autonomous evaluation sequencer for the neuromorphic ASIC test bridge.
// For each enabled input character it:
//   - drives the character selection that feeds the PWM pattern generator,
//   - waits a programmable settle time,
//   - discards one stale XADC result set,
//   - accumulates SAMPLES result sets from the four analog output channels,
//   - classifies the character as the channel with the largest sum.
// Lives in the AXI clock domain.
//
// Ports
//   S_AXI_ACLK                 system clock
//   S_AXI_ARESETN              asynchronous active-low reset
//   start                      one-cycle pulse, begins a sweep when idle
//   abort                      synchronous abort back to idle (highest priority)
//   continuous                 repeat sweeps until abort
//   char_mask[3:0]             bit i enables character i (sampled at sweep start)
//   settle_cycles[SETTLE_W-1:0] settle wait after each selection change
//   meas_valid                 one-cycle pulse, MEASURED_AUX0..3 updated
//   MEASURED_AUX0..3[11:0]     latest XADC channel codes
//   char_select[1:0]           character driven to the pattern generator
//   busy                       high whenever the sequencer is not idle
//   result_valid               one-cycle pulse per classified character
//   result_char/result_class   character just classified / winning channel
//   result_max[11:0]           winning channel average
//   pass_vector[3:0]           bit i = character i classified as class i
//   done                       one-cycle pulse at the end of each sweep
// -----------------------------------------------------------------------------
module asic_eval_sequencer #(
  parameter int SAMPLES  = 4,
  parameter int SETTLE_W = 32
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic                start,
  input  logic                abort,
  input  logic                continuous,
  input  logic [3:0]          char_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                meas_valid,
  input  logic [11:0]         MEASURED_AUX0,
  input  logic [11:0]         MEASURED_AUX1,
  input  logic [11:0]         MEASURED_AUX2,
  input  logic [11:0]         MEASURED_AUX3,
  output logic [1:0]          char_select,
  output logic                busy,
  output logic                result_valid,
  output logic [1:0]          result_char,
  output logic [1:0]          result_class,
  output logic [11:0]         result_max,
  output logic [3:0]          pass_vector,
  output logic                done
);

  localparam int LOG2S = (SAMPLES > 1) ? $clog2(SAMPLES) : 0;
  // Sum of SAMPLES 12-bit codes needs exactly LOG2S extra bits.
  localparam int ACC_W = 12 + LOG2S;
  localparam int CNT_W = LOG2S + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DISCARD = 3'd3,
    ST_ACCUM   = 3'd4,
    ST_DECIDE  = 3'd5,
    ST_NEXT    = 3'd6
  } state_t;

  state_t              state_q;
  logic [3:0]          mask_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_cnt_q;
  logic [1:0]          cur_char_q;
  logic [CNT_W-1:0]    samp_cnt_q;
  logic [ACC_W-1:0]    acc_q [4];

  logic [1:0]          char_select_q;
  logic                busy_q;
  logic                result_valid_q;
  logic [1:0]          result_char_q;
  logic [1:0]          result_class_q;
  logic [11:0]         result_max_q;
  logic [3:0]          pass_q;
  logic                done_q;

  logic [11:0]         aux [4];
  logic [1:0]          win_idx_d;
  logic [ACC_W-1:0]    win_val_d;
  logic [ACC_W-1:0]    win_avg_d;
  logic [2:0]          first_d;   // {found, index} of lowest enabled char in char_mask
  logic [2:0]          adv_d;     // {found, index} of next enabled char above current
  logic                unused_bits;

  assign aux[0] = MEASURED_AUX0;
  assign aux[1] = MEASURED_AUX1;
  assign aux[2] = MEASURED_AUX2;
  assign aux[3] = MEASURED_AUX3;

  // Lowest set bit of mask, returned as {found, index}.
  function automatic logic [2:0] lowest_char(input logic [3:0] mask);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Lowest set bit of mask strictly above cur, returned as {found, index}.
  function automatic logic [2:0] next_char(input logic [3:0] mask,
                                           input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Argmax with strict compare so ties resolve to the lowest channel.
  always_comb begin
    win_idx_d = 2'd0;
    win_val_d = acc_q[0];
    for (int i = 1; i < 4; i++) begin
      if (acc_q[i] > win_val_d) begin
        win_idx_d = 2'(i);
        win_val_d = acc_q[i];
      end
    end
  end

  // Sum fits in ACC_W bits, so the average always fits in the low 12 bits.
  assign win_avg_d   = win_val_d >> LOG2S;
  assign unused_bits = ^win_avg_d;

  assign first_d = lowest_char(char_mask);
  assign adv_d   = next_char(mask_q, cur_char_q);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q        <= ST_IDLE;
      mask_q         <= '0;
      settle_q       <= '0;
      settle_cnt_q   <= '0;
      cur_char_q     <= '0;
      samp_cnt_q     <= '0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
      char_select_q  <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_char_q  <= '0;
      result_class_q <= '0;
      result_max_q   <= '0;
      pass_q         <= '0;
      done_q         <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;

      if (abort) begin
        // char_select and pass_vector deliberately keep their values.
        state_q      <= ST_IDLE;
        busy_q       <= 1'b0;
        settle_cnt_q <= '0;
        samp_cnt_q   <= '0;
        for (int i = 0; i < 4; i++) acc_q[i] <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              mask_q   <= char_mask;
              settle_q <= settle_cycles;
              pass_q   <= '0;
              if (first_d[2]) begin
                cur_char_q <= first_d[1:0];
                busy_q     <= 1'b1;
                state_q    <= ST_SELECT;
              end else begin
                // Empty mask: an immediate, empty sweep.
                done_q <= 1'b1;
              end
            end
          end

          ST_SELECT: begin
            char_select_q <= cur_char_q;
            settle_cnt_q  <= '0;
            samp_cnt_q    <= '0;
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
            state_q       <= ST_SETTLE;
          end

          ST_SETTLE: begin
            if (settle_cnt_q == settle_q) begin
              state_q <= ST_DISCARD;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end

          ST_DISCARD: begin
            // First result set after settling may straddle the change; drop it.
            if (meas_valid) state_q <= ST_ACCUM;
          end

          ST_ACCUM: begin
            if (meas_valid) begin
              for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_q[i] + ACC_W'(aux[i]);
              end
              samp_cnt_q <= samp_cnt_q + CNT_W'(1);
              if (samp_cnt_q == LAST_SAMPLE) state_q <= ST_DECIDE;
            end
          end

          ST_DECIDE: begin
            result_valid_q     <= 1'b1;
            result_char_q      <= cur_char_q;
            result_class_q     <= win_idx_d;
            result_max_q       <= win_avg_d[11:0];
            pass_q[cur_char_q] <= (win_idx_d == cur_char_q);
            state_q            <= ST_NEXT;
          end

          ST_NEXT: begin
            if (adv_d[2]) begin
              cur_char_q <= adv_d[1:0];
              state_q    <= ST_SELECT;
            end else begin
              done_q <= 1'b1;
              if (continuous) begin
                mask_q   <= char_mask;
                settle_q <= settle_cycles;
                pass_q   <= '0;
                if (first_d[2]) begin
                  cur_char_q <= first_d[1:0];
                  state_q    <= ST_SELECT;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end

          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign char_select  = char_select_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_char  = result_char_q;
  assign result_class = result_class_q;
  assign result_max   = result_max_q;
  assign pass_vector  = pass_q;
  assign done         = done_q;

endmodule

// File: tb/tb_asic_eval_sequencer.sv
`timescale 1ns/1ps
module tb_asic_eval_sequencer;

  localparam int SAMPLES  = 4;
  localparam int SETTLE_W = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                continuous = 1'b0;
  logic [3:0]          char_mask = '0;
  logic [SETTLE_W-1:0] settle_cycles = '0;
  logic                meas_valid = 1'b0;
  logic [11:0]         aux0 = '0, aux1 = '0, aux2 = '0, aux3 = '0;

  logic [1:0]  char_select;
  logic        busy;
  logic        result_valid;
  logic [1:0]  result_char;
  logic [1:0]  result_class;
  logic [11:0] result_max;
  logic [3:0]  pass_vector;
  logic        done;

  asic_eval_sequencer #(.SAMPLES(SAMPLES), .SETTLE_W(SETTLE_W)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .start         (start),
    .abort         (abort),
    .continuous    (continuous),
    .char_mask     (char_mask),
    .settle_cycles (settle_cycles),
    .meas_valid    (meas_valid),
    .MEASURED_AUX0 (aux0),
    .MEASURED_AUX1 (aux1),
    .MEASURED_AUX2 (aux2),
    .MEASURED_AUX3 (aux3),
    .char_select   (char_select),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_char   (result_char),
    .result_class  (result_class),
    .result_max    (result_max),
    .pass_vector   (pass_vector),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [1:0]  cls;
    logic [11:0] mx;
  } res_t;

  typedef struct {
    logic       chk_pass;
    logic [3:0] pass;
  } done_t;

  res_t  res_q[$];
  done_t done_q[$];
  res_t  er;
  done_t ed;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int mode = 0;      // 0 none, 1 match model, 2 tie model, 3 every-cycle ramp
  int gap = 0;
  int setn = 0;
  logic sel_watch = 1'b0;
  int bad_sel = 0;

  // Monitor: pops the scoreboard whenever the DUT presents a result or done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sel_watch && (char_select == 2'd1 || char_select == 2'd3)) bad_sel++;
      if (result_valid) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got char=%0d class=%0d max=%h, required no result",
                   result_char, result_class, result_max);
        end else begin
          er = res_q.pop_front();
          if (result_char !== er.ch || result_class !== er.cls || result_max !== er.mx) begin
            errors++;
            $display("FAIL result: got char=%0d class=%0d max=%h, required char=%0d class=%0d max=%h",
                     result_char, result_class, result_max, er.ch, er.cls, er.mx);
          end
        end
      end
      if (done) begin
        done_seen++;
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done with pass=%b, required no done", pass_vector);
        end else begin
          ed = done_q.pop_front();
          if (ed.chk_pass && pass_vector !== ed.pass) begin
            errors++;
            $display("FAIL done_pass: got pass=%b, required %b", pass_vector, ed.pass);
          end
        end
      end
    end
  end

  // XADC stand-in: produces result sets according to the active mode.
  task automatic gen_meas();
    meas_valid = 1'b0;
    if (mode == 1 || mode == 2) begin
      gap++;
      if (gap >= 6) begin
        gap = 0;
        meas_valid = 1'b1;
        aux0 = (char_select == 2'd0) ? 12'h800 : 12'h100;
        aux1 = (char_select == 2'd1) ? 12'h800 : 12'h100;
        aux2 = (char_select == 2'd2) ? 12'h800 : 12'h100;
        aux3 = (char_select == 2'd3) ? 12'h800 : 12'h100;
        if (mode == 2 && char_select == 2'd2) begin
          aux2 = 12'hABC;
          aux3 = 12'hABC;
        end
      end
    end else if (mode == 3) begin
      setn++;
      meas_valid = 1'b1;
      aux0 = 12'(12'h100 + setn);
      aux1 = 12'(12'h300 + 16 * setn);
      aux2 = 12'h050;
      aux3 = 12'(setn);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    gen_meas();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_seen;
    n = 0;
    while (done_seen == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_seen == d0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles, required done", name, budget);
    end
  endtask

  task automatic push_res(input logic [1:0] ch, input logic [1:0] cls, input logic [11:0] mx);
    res_t r;
    r.ch = ch; r.cls = cls; r.mx = mx;
    res_q.push_back(r);
  endtask

  task automatic push_done(input logic chk, input logic [3:0] pass);
    done_t d;
    d.chk_pass = chk; d.pass = pass;
    done_q.push_back(d);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_char_select", char_select, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_char", result_char, 0);
    check("rst_result_class", result_class, 0);
    check("rst_result_max", result_max, 0);
    check("rst_pass_vector", pass_vector, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of accumulation on char 2.
    mode = 1; gap = 0;
    char_mask = 4'b0100; settle_cycles = 2;
    pulse_start();
    repeat (20) tick();
    check("t1_busy_pre_reset", busy, 1);
    check("t1_sel_pre_reset", char_select, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t1_busy_in_reset", busy, 0);
    check("t1_sel_in_reset", char_select, 0);
    check("t1_rv_in_reset", result_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    gap = 0;
    tick();

    char_mask = 4'b0001;
    push_res(2'd0, 2'd0, 12'h800);
    push_done(1'b1, 4'b0001);
    pulse_start();
    wait_done("t1_after_reset", 400);

    // Full mask, settle 10, matching channel wins every char.
    char_mask = 4'b1111; settle_cycles = 10;
    for (int c = 0; c < 4; c++) push_res(2'(c), 2'(c), 12'h800);
    push_done(1'b1, 4'b1111);
    pulse_start();
    repeat (5) tick();
    pulse_start();   // ignored while busy
    wait_done("t2_full", 800);

    // Sparse mask with a tie on char 2.
    mode = 2;
    char_mask = 4'b0101;
    push_res(2'd0, 2'd0, 12'h800);
    push_res(2'd2, 2'd2, 12'hABC);
    push_done(1'b1, 4'b0101);
    pulse_start();
    tick();
    sel_watch = 1'b1;
    wait_done("t3_tie", 800);
    sel_watch = 1'b0;
    check("t3_skipped_select", bad_sel, 0);
    check("t3_pass_hold", pass_vector, 4'b0101);

    // Empty mask: immediate done, pass cleared, never busy.
    mode = 0;
    char_mask = 4'b0000;
    push_done(1'b1, 4'b0000);
    pulse_start();
    check("t6_done_next_cycle", done, 1);
    check("t6_busy", busy, 0);
    check("t6_pass", pass_vector, 0);
    repeat (3) tick();

    // settle 0, result set every cycle; set 1 coincides with start,
    // set 4 is discarded, sets 5..8 are summed: AUX1 avg = 0x300 + 16*6.5 = 0x368.
    char_mask = 4'b0001; settle_cycles = 0;
    setn = 0; mode = 3;
    tick();
    push_res(2'd0, 2'd1, 12'h368);
    push_done(1'b1, 4'b0000);
    pulse_start();
    wait_done("t4_settle0", 100);
    mode = 0;
    tick();

    // Continuous sweeps, abort in the second sweep's settle.
    mode = 1; gap = 0;
    continuous = 1'b1;
    char_mask = 4'b0011; settle_cycles = 10;
    push_res(2'd0, 2'd0, 12'h800);
    push_res(2'd1, 2'd1, 12'h800);
    push_done(1'b0, 4'b0000);
    pulse_start();
    repeat (5) tick();
    pulse_start();   // ignored while busy
    wait_done("t5_first_sweep", 800);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    continuous = 1'b0;
    check("t5_busy_after_abort", busy, 0);
    check("t5_sel_hold", char_select, 0);
    check("t5_done_after_abort", done, 0);
    check("t5_rv_after_abort", result_valid, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("t5_start_abort_idle", busy, 0);
    repeat (150) tick();
    check("t5_busy_final", busy, 0);

    check("scoreboard_drained", res_q.size() + done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
